mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_grant.sv | 47 ++++
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction-fetch / data-memory arbiter.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin tie break).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ISSUE   = 2'b01,
        BUSY    = 2'b10,
        RELEASE = 2'b11
    } arb_state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_e;

    localparam int unsigned TMR_W = 16;

endpackage

// File: rtl/mem_arb_grant.sv
// Two-requester grant selection: fixed dm-over-fetch priority by default,
// alternating on ties when MEM_ARB_ROUND_ROBIN_EN is defined.
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic dm_req,
    input  logic take,
    output logic gnt_dm
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_dm_q;
    logic last_dm_d;

    always_comb begin
        if (if_req && dm_req) begin
            gnt_dm = !last_dm_q;
        end else begin
            gnt_dm = dm_req;
        end
        last_dm_d = last_dm_q;
        if (take) begin
            last_dm_d = gnt_dm;
        end
    end

    // Pointer resets to "dm granted last" so fetch wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_dm_q <= 1'b1;
        end else begin
            last_dm_q <= last_dm_d;
        end
    end
`else
    logic unused_rr;

    always_comb begin
        gnt_dm    = dm_req;
        unused_rr = clk ^ reset ^ if_req ^ take;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto one memory-controller port.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (see mem_arb_grant).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ADWIDTH = 32,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               if_req,
    input  logic [ADWIDTH-1:0] if_addr,
    output logic [WIDTH-1:0]   if_rdata,
    output logic               if_done,
    output logic               if_err,
    input  logic               dm_req,
    input  logic               dm_rw,
    input  logic [ADWIDTH-1:0] dm_addr,
    input  logic [WIDTH-1:0]   dm_wdata,
    output logic [WIDTH-1:0]   dm_rdata,
    output logic               dm_done,
    output logic               dm_err,
    output logic               mc_valid,
    output logic               mc_rw,
    output logic [ADWIDTH-1:0] mc_addr,
    output logic [WIDTH-1:0]   mc_wdata,
    input  logic [WIDTH-1:0]   mc_rdata,
    input  logic               mc_ready
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    arb_state_e         state_q, state_d;
    grant_e             gnt_q, gnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               mc_valid_q, mc_valid_d;
    logic               mc_rw_q, mc_rw_d;
    logic [ADWIDTH-1:0] mc_addr_q, mc_addr_d;
    logic [WIDTH-1:0]   mc_wdata_q, mc_wdata_d;
    logic [WIDTH-1:0]   if_rdata_q, if_rdata_d;
    logic [WIDTH-1:0]   dm_rdata_q, dm_rdata_d;
    logic               if_done_q, if_done_d;
    logic               if_err_q, if_err_d;
    logic               dm_done_q, dm_done_d;
    logic               dm_err_q, dm_err_d;

    logic               gnt_dm;
    logic               take;
    logic [ADWIDTH-1:0] sel_addr;
    logic               fin;
    logic               fin_err;
    logic               fin_dm;
    logic [WIDTH-1:0]   fin_data;

    mem_arb_grant u_grant (
        .clk    (clk),
        .reset  (reset),
        .if_req (if_req),
        .dm_req (dm_req),
        .take   (take),
        .gnt_dm (gnt_dm)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        timer_d    = timer_q;
        mc_valid_d = mc_valid_q;
        mc_rw_d    = mc_rw_q;
        mc_addr_d  = mc_addr_q;
        mc_wdata_d = mc_wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_done_d  = 1'b0;
        if_err_d   = 1'b0;
        dm_done_d  = 1'b0;
        dm_err_d   = 1'b0;
        take       = 1'b0;
        fin        = 1'b0;
        fin_err    = 1'b0;
        fin_dm     = (gnt_q == GNT_DM);
        fin_data   = mc_rdata;
        sel_addr   = gnt_dm ? dm_addr : if_addr;

        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    take  = 1'b1;
                    gnt_d = gnt_dm ? GNT_DM : GNT_IF;
                    // Misaligned requests complete with an error without touching the bus.
                    if (sel_addr[1:0] != 2'b00) begin
                        fin      = 1'b1;
                        fin_err  = 1'b1;
                        fin_dm   = gnt_dm;
                        fin_data = '0;
                    end else begin
                        state_d    = ISSUE;
                        timer_d    = '0;
                        mc_valid_d = 1'b1;
                        mc_rw_d    = gnt_dm & dm_rw;
                        mc_addr_d  = sel_addr;
                        mc_wdata_d = gnt_dm ? dm_wdata : '0;
                    end
                end
            end
            ISSUE, BUSY: begin
                if (state_q == BUSY && mc_ready) begin
                    fin = 1'b1;
                end else if (timer_q == TMR_LAST) begin
                    fin      = 1'b1;
                    fin_err  = 1'b1;
                    fin_data = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                    if (state_q == ISSUE && !mc_ready) begin
                        state_d = BUSY;
                    end
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (fin) begin
            state_d    = RELEASE;
            mc_valid_d = 1'b0;
            if (fin_dm) begin
                dm_done_d  = 1'b1;
                dm_err_d   = fin_err;
                dm_rdata_d = fin_data;
            end else begin
                if_done_d  = 1'b1;
                if_err_d   = fin_err;
                if_rdata_d = fin_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= GNT_IF;
            timer_q    <= '0;
            mc_valid_q <= 1'b0;
            mc_rw_q    <= 1'b0;
            mc_addr_q  <= '0;
            mc_wdata_q <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_done_q  <= 1'b0;
            if_err_q   <= 1'b0;
            dm_done_q  <= 1'b0;
            dm_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            timer_q    <= timer_d;
            mc_valid_q <= mc_valid_d;
            mc_rw_q    <= mc_rw_d;
            mc_addr_q  <= mc_addr_d;
            mc_wdata_q <= mc_wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_done_q  <= if_done_d;
            if_err_q   <= if_err_d;
            dm_done_q  <= dm_done_d;
            dm_err_q   <= dm_err_d;
        end
    end

    assign if_rdata = if_rdata_q;
    assign if_done  = if_done_q;
    assign if_err   = if_err_q;
    assign dm_rdata = dm_rdata_q;
    assign dm_done  = dm_done_q;
    assign dm_err   = dm_err_q;
    assign mc_valid = mc_valid_q;
    assign mc_rw    = mc_rw_q;
    assign mc_addr  = mc_addr_q;
    assign mc_wdata = mc_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a registered memory-controller model.
module tb_mem_arbiter;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_done, if_err;
    logic        dm_req = 1'b0;
    logic        dm_rw = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_done, dm_err;
    logic        mc_valid, mc_rw;
    logic [31:0] mc_addr, mc_wdata;
    logic [31:0] mc_rdata = '0;
    logic        mc_ready = 1'b1;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(32), .ADWIDTH(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .if_err(if_err),
        .dm_req(dm_req), .dm_rw(dm_rw), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_err(dm_err),
        .mc_valid(mc_valid), .mc_rw(mc_rw), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
        .mc_rdata(mc_rdata), .mc_ready(mc_ready)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic        issue;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb_if[$];
    exp_t sb_dm[$];
    bit   done_order[$];
    int   n_vec = 0;
    int   n_mis = 0;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory-controller model: reacts one half-cycle after seeing mc_valid.
    int busy_n = 1;
    bit hang = 0;
    bit m_active = 0;
    bit m_fin = 0;
    int m_cnt = 0;

    always @(negedge clk) begin
        if (reset) begin
            mc_ready = 1'b1;
            mc_rdata = '0;
            m_active = 0;
            m_fin    = 0;
        end else begin
            if (!mc_valid) m_fin = 0;
            if (m_active) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    mc_ready = 1'b1;
                    mc_rdata = mem_f(mc_addr);
                    m_active = 0;
                    m_fin    = 1;
                end
            end else if (mc_valid && !m_fin) begin
                if (hang) begin
                    m_fin = 1;
                end else begin
                    m_active = 1;
                    m_cnt    = busy_n;
                    mc_ready = 1'b0;
                end
            end
        end
    end

    // Monitor: captures the issued bus request and checks completions against the scoreboard.
    bit          prev_v = 0;
    bit          issued = 0;
    bit          stab_bad = 0;
    bit          last_dm = 1;
    logic        cap_rw;
    logic [31:0] cap_addr, cap_wdata;
    logic [31:0] prev_if_rd = '0;
    logic [31:0] prev_dm_rd = '0;
    exp_t        mon_e;

    task automatic chk_done(input string p, input exp_t e, input logic err, input logic [31:0] rd);
        chk({p, "_err"}, err, e.err);
        chk({p, "_rdata"}, rd, e.rdata);
        chk({p, "_issued"}, issued, e.issue);
        if (e.issue) begin
            chk({p, "_mc_addr"}, cap_addr, e.addr);
            chk({p, "_mc_rw"}, cap_rw, e.rw);
            if (e.rw) chk({p, "_mc_wdata"}, cap_wdata, e.wdata);
            chk({p, "_mc_stable"}, stab_bad, 1'b0);
        end
        chk({p, "_valid_low"}, mc_valid, 1'b0);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            issued   = 0;
            stab_bad = 0;
            last_dm  = 1;
        end else begin
            if (mc_valid && !prev_v) begin
                issued    = 1;
                cap_rw    = mc_rw;
                cap_addr  = mc_addr;
                cap_wdata = mc_wdata;
            end else if (mc_valid && (mc_rw !== cap_rw || mc_addr !== cap_addr || mc_wdata !== cap_wdata)) begin
                stab_bad = 1;
            end
            if (if_done && dm_done) chk("dual_done", 1'b1, 1'b0);
            if (if_err && !if_done) chk("if_err_stray", 1'b1, 1'b0);
            if (dm_err && !dm_done) chk("dm_err_stray", 1'b1, 1'b0);
            if (!if_done && if_rdata !== prev_if_rd) chk("if_rdata_hold", if_rdata, prev_if_rd);
            if (!dm_done && dm_rdata !== prev_dm_rd) chk("dm_rdata_hold", dm_rdata, prev_dm_rd);
            if (dm_done) begin
                if (sb_dm.size() == 0) chk("dm_spurious_done", 1'b1, 1'b0);
                else begin
                    mon_e = sb_dm.pop_front();
                    chk_done("dm", mon_e, dm_err, dm_rdata);
                end
                done_order.push_back(1'b1);
                last_dm  = 1;
                issued   = 0;
                stab_bad = 0;
            end
            if (if_done) begin
                if (sb_if.size() == 0) chk("if_spurious_done", 1'b1, 1'b0);
                else begin
                    mon_e = sb_if.pop_front();
                    chk_done("if", mon_e, if_err, if_rdata);
                end
                done_order.push_back(1'b0);
                last_dm  = 0;
                issued   = 0;
                stab_bad = 0;
            end
        end
        prev_v     = mc_valid;
        prev_if_rd = if_rdata;
        prev_dm_rd = dm_rdata;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic if_txn(input logic [31:0] addr, input int exp_lat);
        exp_t e;
        int   lat;
        e.issue = (addr[1:0] == 2'b00);
        e.err   = !e.issue;
        e.rdata = e.issue ? mem_f(addr) : 32'h0;
        e.rw    = 1'b0;
        e.addr  = addr;
        e.wdata = '0;
        sb_if.push_back(e);
        if_addr = addr;
        if_req  = 1'b1;
        lat     = 0;
        do begin
            step(1);
            lat++;
        end while (!if_done && lat < 400);
        if (!if_done) chk("if_wait_done", 1'b0, 1'b1);
        else if (exp_lat > 0) chk("if_latency", 64'(lat), 64'(exp_lat));
        if_req = 1'b0;
    endtask

    task automatic dm_txn(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit tmo, input int exp_lat, input bit keep);
        exp_t e;
        int   lat;
        e.issue = (addr[1:0] == 2'b00);
        e.err   = !e.issue || tmo;
        e.rdata = e.err ? 32'h0 : mem_f(addr);
        e.rw    = rw;
        e.addr  = addr;
        e.wdata = wdata;
        sb_dm.push_back(e);
        dm_rw    = rw;
        dm_addr  = addr;
        dm_wdata = wdata;
        dm_req   = 1'b1;
        lat      = 0;
        do begin
            step(1);
            lat++;
        end while (!dm_done && lat < 400);
        if (!dm_done) chk("dm_wait_done", 1'b0, 1'b1);
        else if (exp_lat > 0) chk("dm_latency", 64'(lat), 64'(exp_lat));
        if (!keep) dm_req = 1'b0;
    endtask

    bit          exp_first;
    logic [31:0] ra;

    initial begin
        // Reset behaviour, including a request held during reset.
        step(2);
        if_req  = 1'b1;
        if_addr = 32'h10;
        step(2);
        chk("rst_mc_valid", mc_valid, 1'b0);
        chk("rst_mc_rw", mc_rw, 1'b0);
        chk("rst_mc_addr", mc_addr, 32'h0);
        chk("rst_if_done", if_done, 1'b0);
        chk("rst_dm_done", dm_done, 1'b0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        if_req = 1'b0;
        reset  = 1'b0;
        step(2);

        // Fetch read with a three-cycle busy controller.
        busy_n = 3;
        if_txn(32'h10, 5);
        step(2);

        // Simultaneous requests.
        busy_n = 2;
        done_order.delete();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_first = !last_dm;
`else
        exp_first = 1'b1;
`endif
        fork
            if_txn(32'h40, 0);
            dm_txn(1'b1, 32'h20, 32'h12345678, 1'b0, 0, 1'b0);
        join
        if (done_order.size() > 0) chk("first_served_dm", done_order[0], exp_first);
        else chk("first_served_seen", 1'b0, 1'b1);
        step(2);

        // Timeout: controller never goes busy.
        hang = 1;
        dm_txn(1'b0, 32'h30, 32'h0, 1'b1, TMO + 1, 1'b0);
        hang = 0;
        step(2);

        // Misaligned requests on both ports.
        dm_txn(1'b0, 32'h22, 32'h0, 1'b0, 1, 1'b0);
        step(1);
        if_txn(32'h13, 1);
        step(2);

        // Reset in the middle of a busy transaction.
        busy_n  = 10;
        dm_rw   = 1'b0;
        dm_addr = 32'h50;
        dm_req  = 1'b1;
        step(4);
        reset  = 1'b1;
        dm_req = 1'b0;
        step(1);
        chk("midrst_mc_valid", mc_valid, 1'b0);
        chk("midrst_mc_addr", mc_addr, 32'h0);
        chk("midrst_dm_done", dm_done, 1'b0);
        chk("midrst_if_rdata", if_rdata, 32'h0);
        chk("midrst_dm_rdata", dm_rdata, 32'h0);
        reset = 1'b0;
        step(3);
        busy_n = 2;
        dm_txn(1'b0, 32'h50, 32'h0, 1'b0, 4, 1'b0);
        step(2);

        // Back-to-back with req held across done.
        busy_n = 1;
        dm_txn(1'b1, 32'h60, 32'hCAFE0001, 1'b0, 3, 1'b1);
        dm_txn(1'b0, 32'h64, 32'h0, 1'b0, 4, 1'b0);
        step(2);

        // A few randomized single transactions on alternating ports.
        for (int i = 0; i < 6; i++) begin
            busy_n = $urandom_range(4, 1);
            ra     = 32'($urandom_range(1023, 0)) << 2;
            if (i % 2 == 1) if_txn(ra, busy_n + 2);
            else dm_txn(logic'(i > 2), ra, $urandom, 1'b0, busy_n + 2, 1'b0);
            step(1);
        end

        step(4);
        chk("sb_if_drained", 64'(sb_if.size()), 64'd0);
        chk("sb_dm_drained", 64'(sb_dm.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
